fpu_unpack_pipe: RTL and testbench

//  Pipelined, parametrised IEEE-754 unpacker for the FPU operand path. Converts a packed float into

---
 rtl/fpu_unpack_pipe.sv | 149 ++++++++++++++
 tb/tb_fpu_unpack_pipe.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_unpack_pipe.sv
// rtl/fpu_unpack_pipe.sv - two-stage IEEE-754 operand unpacker with valid/ready on both sides
// Macro FPU_UNPACK_DENORM_EN: when defined, denormals are normalised instead of flushed to zero.
module fpu_unpack_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+FRAC_W:0] in_data,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic [EXP_W:0]        out_exp,
  output logic [FRAC_W:0]       out_mant,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_is_zero,
  output logic                  out_is_inf,
  output logic                  out_is_nan,
  output logic                  out_is_snan,
  output logic                  out_is_denorm
);
  localparam logic [EXP_W:0] BIAS = {2'b00, {(EXP_W-1){1'b1}}};

  logic              in_sign;
  logic [EXP_W-1:0]  in_e;
  logic [FRAC_W-1:0] in_f;
  logic              e_max, e_zero, f_zero;

  assign {in_sign, in_e, in_f} = in_data;
  assign e_max  = &in_e;
  assign e_zero = ~|in_e;
  assign f_zero = ~|in_f;

  logic              s1_v;
  logic              s1_sign;
  logic [EXP_W-1:0]  s1_e;
  logic [FRAC_W-1:0] s1_f;
  logic [TAG_W-1:0]  s1_tag;
  logic              s1_zero, s1_inf, s1_nan, s1_snan, s1_denorm;

  logic s1_rdy, s2_rdy;

  assign s2_rdy   = !out_valid || out_ready;
  assign s1_rdy   = !s1_v || s2_rdy;
  assign in_ready = s1_rdy;

  // S1: capture the raw fields and classify
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v      <= 1'b0;
      s1_sign   <= 1'b0;
      s1_e      <= '0;
      s1_f      <= '0;
      s1_tag    <= '0;
      s1_zero   <= 1'b0;
      s1_inf    <= 1'b0;
      s1_nan    <= 1'b0;
      s1_snan   <= 1'b0;
      s1_denorm <= 1'b0;
    end else if (s1_rdy) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_sign   <= in_sign;
        s1_e      <= in_e;
        s1_f      <= in_f;
        s1_tag    <= in_tag;
        s1_zero   <= e_zero && f_zero;
        s1_inf    <= e_max && f_zero;
        s1_nan    <= e_max && !f_zero;
        s1_snan   <= e_max && !f_zero && !in_f[FRAC_W-1];
        s1_denorm <= e_zero && !f_zero;
      end
    end
  end

  logic [EXP_W:0]  n_exp;
  logic [FRAC_W:0] n_mant;
  logic            n_zero;

`ifdef FPU_UNPACK_DENORM_EN
  localparam int             LZ_W = $clog2(FRAC_W + 1);
  localparam logic [EXP_W:0] ONE  = {{EXP_W{1'b0}}, 1'b1};
  logic [LZ_W-1:0] lz;
  logic            lz_found;
`endif

  // S2 datapath: exponent unbias and mantissa normalisation
  always_comb begin
    n_exp  = '0;
    n_mant = '0;
    n_zero = s1_zero;
`ifdef FPU_UNPACK_DENORM_EN
    lz       = '0;
    lz_found = 1'b0;
    for (int i = FRAC_W - 1; i >= 0; i--) begin
      if (!lz_found) begin
        if (s1_f[i]) lz_found = 1'b1;
        else         lz = lz + LZ_W'(1);
      end
    end
`endif
    if (s1_nan) begin
      n_mant = {1'b1, s1_f};
    end else if (s1_denorm) begin
`ifdef FPU_UNPACK_DENORM_EN
      n_mant = {s1_f, 1'b0} << lz;
      n_exp  = ONE - BIAS - {{(EXP_W+1-LZ_W){1'b0}}, lz} - ONE;
`else
      n_zero = 1'b1;
`endif
    end else if (!s1_zero && !s1_inf) begin
      n_exp  = {1'b0, s1_e} - BIAS;
      n_mant = {1'b1, s1_f};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_sign      <= 1'b0;
      out_exp       <= '0;
      out_mant      <= '0;
      out_tag       <= '0;
      out_is_zero   <= 1'b0;
      out_is_inf    <= 1'b0;
      out_is_nan    <= 1'b0;
      out_is_snan   <= 1'b0;
      out_is_denorm <= 1'b0;
    end else if (s2_rdy) begin
      out_valid <= s1_v;
      if (s1_v) begin
        out_sign      <= s1_sign;
        out_exp       <= n_exp;
        out_mant      <= n_mant;
        out_tag       <= s1_tag;
        out_is_zero   <= n_zero;
        out_is_inf    <= s1_inf;
        out_is_nan    <= s1_nan;
        out_is_snan   <= s1_snan;
        out_is_denorm <= s1_denorm;
      end
    end
  end

endmodule

// File: tb/tb_fpu_unpack_pipe.sv
// tb/tb_fpu_unpack_pipe.sv - self-checking bench for fpu_unpack_pipe (default parameters)
module tb_fpu_unpack_pipe;

  typedef struct {
    logic [31:0] data;
    logic        sign;
    logic [8:0]  exp;
    logic [23:0] mant;
    logic [4:0]  flags; // {zero, inf, nan, snan, denorm}
  } vec_t;

  typedef struct {
    logic [42:0] res;
    int          cyc;
  } sb_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [8:0]  out_exp;
  logic [23:0] out_mant;
  logic [3:0]  out_tag;
  logic        out_is_zero, out_is_inf, out_is_nan, out_is_snan, out_is_denorm;

  fpu_unpack_pipe #(.EXP_W(8), .FRAC_W(23), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant), .out_tag(out_tag),
    .out_is_zero(out_is_zero), .out_is_inf(out_is_inf), .out_is_nan(out_is_nan),
    .out_is_snan(out_is_snan), .out_is_denorm(out_is_denorm)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   nres = 0;
  int   first_cyc = 0;
  int   last_cyc = 0;
  bit   lat_chk = 0;
  bit   rnd_ready = 0;
  sb_t  sb[$];
  vec_t vt[12];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [42:0] act_word();
    return {out_sign, out_exp, out_mant, out_is_zero, out_is_inf, out_is_nan,
            out_is_snan, out_is_denorm, out_tag};
  endfunction

  task automatic push_exp(input vec_t v, input logic [3:0] t);
    sb_t e;
    e.res = {v.sign, v.exp, v.mant, v.flags, t};
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic send(input vec_t v, input logic [3:0] t);
    int  n;
    bit  ok;
    n  = 0;
    ok = 0;
    in_valid = 1'b1;
    in_data  = v.data;
    in_tag   = t;
    do begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      ok = in_ready;
      n++;
      if (ok) push_exp(v, t);
      @(posedge clk);
      #1;
    end while (!ok && n < 200);
    if (!ok) chk("send_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("result", 64'(act_word()), 64'(e.res));
        if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'd2);
        nres++;
        if (nres == 1) first_cyc = cyc;
        last_cyc = cyc;
      end
    end
  end

  initial begin
    logic [42:0] snap;
    int          acc;
    int          n;
    vec_t        rv;
    logic [7:0]  re;
    logic [31:0] rf;

    vt[0]  = '{32'h3F800000, 1'b0, 9'h000, 24'h800000, 5'b00000};
    vt[1]  = '{32'hFF800000, 1'b1, 9'h000, 24'h000000, 5'b01000};
    vt[2]  = '{32'h7F800001, 1'b0, 9'h000, 24'h800001, 5'b00110};
    vt[3]  = '{32'h7FC00000, 1'b0, 9'h000, 24'hC00000, 5'b00100};
    vt[4]  = '{32'h00000000, 1'b0, 9'h000, 24'h000000, 5'b10000};
    vt[5]  = '{32'h80000000, 1'b1, 9'h000, 24'h000000, 5'b10000};
    vt[6]  = '{32'hC0490FDB, 1'b1, 9'h001, 24'hC90FDB, 5'b00000};
    vt[7]  = '{32'h00800000, 1'b0, 9'h182, 24'h800000, 5'b00000};
    vt[8]  = '{32'h7F7FFFFF, 1'b0, 9'h07F, 24'hFFFFFF, 5'b00000};
`ifdef FPU_UNPACK_DENORM_EN
    vt[9]  = '{32'h00000001, 1'b0, 9'h16B, 24'h800000, 5'b00001};
    vt[10] = '{32'h80400000, 1'b1, 9'h181, 24'h800000, 5'b00001};
    vt[11] = '{32'h007FFFFF, 1'b0, 9'h181, 24'hFFFFFE, 5'b00001};
`else
    vt[9]  = '{32'h00000001, 1'b0, 9'h000, 24'h000000, 5'b10001};
    vt[10] = '{32'h80400000, 1'b1, 9'h000, 24'h000000, 5'b10001};
    vt[11] = '{32'h007FFFFF, 1'b0, 9'h000, 24'h000000, 5'b10001};
`endif

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", 64'({out_valid, act_word()}), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // table streamed back-to-back: checks values, 2-cycle latency and no bubbles
    out_ready = 1'b1;
    nres = 0;
    lat_chk = 1;
    for (int i = 0; i < 12; i++) send(vt[i], 4'(i));
    drain();
    lat_chk = 0;
    chk("stream_count", 64'(nres), 64'd12);
    chk("stream_contiguous", 64'(last_cyc - first_cyc), 64'd11);

    // stall: three offered, two accepted, outputs frozen, then released in order
    out_ready = 1'b0;
    acc = 0;
    nres = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = vt[acc].data;
      in_tag   = 4'(acc);
      @(negedge clk);
      if (in_ready) begin
        push_exp(vt[acc], 4'(acc));
        acc++;
      end
      @(posedge clk);
      #1;
    end
    chk("stall_accepted", 64'(acc), 64'd2);
    @(negedge clk);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    snap = act_word();
    repeat (3) @(negedge clk);
    chk("stall_frozen", 64'(act_word()), 64'(snap));
    chk("stall_head_tag", 64'(out_tag), 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(vt[2], 4'd2);
    drain();
    chk("stall_release_count", 64'(nres), 64'd3);

    // random normals under random backpressure
    rnd_ready = 1;
    for (int i = 0; i < 8; i++) begin
      re = 8'($urandom_range(1, 254));
      rf = $urandom;
      rv.sign  = 1'($urandom_range(0, 1));
      rv.data  = {rv.sign, re, rf[22:0]};
      rv.exp   = {1'b0, re} - 9'd127;
      rv.mant  = {1'b1, rf[22:0]};
      rv.flags = 5'b00000;
      send(rv, 4'(i + 3));
    end
    rnd_ready = 0;
    out_ready = 1'b1;
    drain();

    // reset with a full pipe discards both operands
    out_ready = 1'b0;
    send(vt[6], 4'hA);
    send(vt[7], 4'hB);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midreset_outputs", 64'({out_valid, act_word()}), 64'd0);
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("midreset_no_emit", 64'(n), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
